// File: rtl/soc_pkg.sv
// -----------------------------------------------------------------------------
// soc_pkg
// Shared types and constants for the SoC memory arbiter.
//   arb_state_t     : arbiter sequencer states
//   arb_req_t       : requester identity (fetch port / load-store port)
//   MEM_LATENCY_MAX : largest supported memory read latency
//   LAT_CNT_W       : width of the latency down-counter
// -----------------------------------------------------------------------------
package soc_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } arb_state_t;

    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_D  = 1'b1
    } arb_req_t;

    localparam int MEM_LATENCY_MAX = 4;
    localparam int LAT_CNT_W       = $clog2(MEM_LATENCY_MAX);

endpackage : soc_pkg

// File: rtl/mem_arb_grant.sv
// -----------------------------------------------------------------------------
// mem_arb_grant
// Combinational winner select between the fetch and load/store requesters.
// Build option MEM_ARB_RR_EN:
//   defined   : round-robin; a last-grant register picks the requester that
//               was not granted most recently when both are valid. It resets
//               to "data" so the first contested grant goes to fetch.
//   undefined : fixed priority, data wins over fetch; no state at all.
// Ports:
//   clk, reset  : clock / async active-high reset (round-robin build only)
//   accept      : a handshake completes this cycle (round-robin build only)
//   if_valid    : fetch request valid
//   d_valid     : load/store request valid
//   winner      : selected requester (meaningful only when a valid is high)
// -----------------------------------------------------------------------------
module mem_arb_grant
    import soc_pkg::*;
(
`ifdef MEM_ARB_RR_EN
    input  logic     clk,
    input  logic     reset,
    input  logic     accept,
`endif
    input  logic     if_valid,
    input  logic     d_valid,
    output arb_req_t winner
);

`ifdef MEM_ARB_RR_EN
    arb_req_t last_q;
    arb_req_t last_d;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q <= REQ_D;
        end else begin
            last_q <= last_d;
        end
    end

    // NOTE: every combinational output gets a default first, so no path
    // through the block can leave a value unassigned and infer a latch.
    always_comb begin
        winner = REQ_D;
        if (if_valid && d_valid) begin
            winner = (last_q == REQ_D) ? REQ_IF : REQ_D;
        end else if (if_valid) begin
            winner = REQ_IF;
        end
        last_d = accept ? winner : last_q;
    end
`else
    always_comb begin
        winner = REQ_D;
        if (if_valid && !d_valid) begin
            winner = REQ_IF;
        end
    end
`endif

endmodule : mem_arb_grant

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one single-port instruction/data memory between the CPU fetch port
// and the load/store port. One transaction in flight: IDLE accepts a request,
// ACCESS drives the memory for one enable cycle, WAIT counts out the memory
// latency and captures read data, RESP pulses the winner's response.
// Build option MEM_ARB_RR_EN selects round-robin instead of data-over-fetch
// priority (see mem_arb_grant).
// Parameters: ADDR_W, DATA_W, MEM_LATENCY (1..MEM_LATENCY_MAX)
// Ports:
//   clk, reset                   : clock, async active-high reset
//   if_req_valid/_ready, if_addr : fetch request handshake
//   if_rsp_valid, if_rdata       : fetch response pulse and held data
//   d_req_valid/_ready, d_addr,
//   d_we, d_wstrb, d_wdata       : load/store request handshake
//   d_rsp_valid, d_rdata         : load/store response pulse and held data
//   mem_en, mem_we, mem_wstrb,
//   mem_addr, mem_wdata          : memory command, non-zero only in ACCESS
//   mem_rdata                    : memory read data, MEM_LATENCY after mem_en
// Readys are combinational; every other output is registered.
// -----------------------------------------------------------------------------
module mem_arbiter
    import soc_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = 1
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                if_req_valid,
    output logic                if_req_ready,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_rsp_valid,
    output logic [DATA_W-1:0]   if_rdata,

    input  logic                d_req_valid,
    output logic                d_req_ready,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_wstrb,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_rsp_valid,
    output logic [DATA_W-1:0]   d_rdata,

    output logic                mem_en,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_wstrb,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int STRB_W = DATA_W / 8;

    arb_state_t             state_q,      state_d;
    logic [LAT_CNT_W-1:0]   cnt_q,        cnt_d;
    arb_req_t               owner_q,      owner_d;
    logic                   ready_en_q;
    logic                   mem_en_q,     mem_en_d;
    logic                   mem_we_q,     mem_we_d;
    logic [STRB_W-1:0]      mem_wstrb_q,  mem_wstrb_d;
    logic [ADDR_W-1:0]      mem_addr_q,   mem_addr_d;
    logic [DATA_W-1:0]      mem_wdata_q,  mem_wdata_d;
    logic                   if_rsp_q,     if_rsp_d;
    logic                   d_rsp_q,      d_rsp_d;
    logic [DATA_W-1:0]      if_rdata_q,   if_rdata_d;
    logic [DATA_W-1:0]      d_rdata_q,    d_rdata_d;

    arb_req_t               winner;
    logic                   accept;

    mem_arb_grant u_grant (
`ifdef MEM_ARB_RR_EN
        .clk      (clk),
        .reset    (reset),
        .accept   (accept),
`endif
        .if_valid (if_req_valid),
        .d_valid  (d_req_valid),
        .winner   (winner)
    );

    // Readys stay low on the first cycle after reset release; ready_en_q
    // only rises at the first clock edge that sees reset low.
    always_comb begin
        if_req_ready = 1'b0;
        d_req_ready  = 1'b0;
        if (state_q == IDLE && ready_en_q) begin
            if_req_ready = if_req_valid && (winner == REQ_IF);
            d_req_ready  = d_req_valid  && (winner == REQ_D);
        end
        accept = (if_req_valid && if_req_ready) || (d_req_valid && d_req_ready);
    end

    // The mem_* registers double as the latched request: they load on
    // acceptance and clear on every other edge, so they are non-zero only in
    // ACCESS, which lasts exactly one cycle.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        owner_d     = owner_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_wstrb_d = '0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        if_rsp_d    = 1'b0;
        d_rsp_d     = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    owner_d  = winner;
                    state_d  = ACCESS;
                    mem_en_d = 1'b1;
                    if (winner == REQ_D) begin
                        mem_we_d    = d_we;
                        mem_wstrb_d = d_wstrb;
                        mem_addr_d  = d_addr;
                        mem_wdata_d = d_wdata;
                    end else begin
                        mem_addr_d  = if_addr;
                    end
                end
            end
            ACCESS: begin
                cnt_d   = LAT_CNT_W'(MEM_LATENCY - 1);
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                    if (owner_q == REQ_IF) begin
                        if_rsp_d   = 1'b1;
                        if_rdata_d = mem_rdata;
                    end else begin
                        d_rsp_d    = 1'b1;
                        d_rdata_d  = mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: only control and output registers need reset; there is no
    // storage array here, and an aborted transaction is simply dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            owner_q     <= REQ_IF;
            ready_en_q  <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_wstrb_q <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rsp_q    <= 1'b0;
            d_rsp_q     <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            owner_q     <= owner_d;
            ready_en_q  <= 1'b1;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_wstrb_q <= mem_wstrb_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rsp_q    <= if_rsp_d;
            d_rsp_q     <= d_rsp_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign mem_en       = mem_en_q;
    assign mem_we       = mem_we_q;
    assign mem_wstrb    = mem_wstrb_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign if_rsp_valid = if_rsp_q;
    assign if_rdata     = if_rdata_q;
    assign d_rsp_valid  = d_rsp_q;
    assign d_rdata      = d_rdata_q;

endmodule : mem_arbiter
